mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register.
- Holds the data memory and performs word, halfword and byte stores and loads with sign or zero extension.
- Selects the write-back result and passes the register-write controls and PC through to MEM/WB.
- After reset it runs a clear sequencer that zeroes the memory and stalls the pipeline until the clear is done.

Parameters:
- ADDR_WIDTH, 12, word-address width. Depth is 2^ADDR_WIDTH words (default 4096 words = 16 KB).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- MemWE  in  1  store enable, from EX/MEM.
- MemOp  in  3  access type: 000 word; 001 half unsigned; 010 half signed; 011 byte unsigned; 100 byte signed. Others are treated as word.
- Addr  in  32  byte address (ALU result).
- WData  in  32  store data, already forwarded.
- ResultIn  in  32  ALU result.
- ResultSel  in  2  write-back source: 00 ALU; 01 memory load; 10 PCIn+8; 11 ALU.
- A3In  in  5  destination register.
- RegWEIn  in  1  register write enable.
- PCIn  in  32  instruction PC.
- ResultOut  out  32  to MEM/WB ResultIn.
- A3Out  out  5  to MEM/WB A3In.
- RegWEOut  out  1  to MEM/WB RegWEIn.
- PCOut  out  32  to MEM/WB PCIn.
- Stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
- AddrErr  out  1  misaligned access flag.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- State machine: two states, CLEAR and READY, plus a clear counter of ADDR_WIDTH bits.
- Reset (reset==0):
  - state=CLEAR, counter=0, immediately and independent of clk.
  - Stall=1, RegWEOut=0, ResultOut=0.
  - A3Out and PCOut are combinational pass-throughs at all times.
- CLEAR:
  - Each posedge writes 0 to mem[counter] and increments counter.
  - On the edge where counter==2^ADDR_WIDTH-1 the last word is written and state becomes READY.
  - Stall is 1 for exactly 2^ADDR_WIDTH cycles after reset rises.
- Outputs while CLEAR:
  - Stall=1, RegWEOut=0, ResultOut=0, AddrErr=0.
  - MemWE is ignored, so no user writes occur.
- READY: Stall=0. The block stays in READY until the next reset.
- Reset asserted mid-clear: counter returns to 0 and the clear restarts from word 0 after release.
- Word index is Addr[ADDR_WIDTH+1:2]. Higher address bits are ignored and the address wraps modulo depth.
- Alignment:
  - Word access needs Addr[1:0]==00.
  - Halfword access needs Addr[0]==0.
  - Byte access is always aligned.
  - AddrErr is combinational. It is asserted for a misaligned access only when MemWE==1 or ResultSel==01, and only in READY.
- Stores:
  - Synchronous at posedge when MemWE & READY & !AddrErr.
  - SW writes all 4 bytes.
  - SH writes the lane selected by Addr[1] (0 = bits 15:0, 1 = bits 31:16) with WData[15:0].
  - SB writes byte lane Addr[1:0] (00 = bits 7:0 … 11 = bits 31:24) with WData[7:0].
  - Other bytes of the word are unchanged.
- Loads:
  - Combinational read of mem[index]. The lane is selected as for stores.
  - Unsigned types zero-extend; signed types sign-extend from bit 15 or bit 7.
  - A misaligned load returns 0.
- Read during a write to the same word in one cycle shows pre-edge data. The new data is visible after the edge.
- ResultOut (READY): mux by ResultSel; PC+8 uses modulo-2^32 add.
- RegWEOut (READY): RegWEIn & !(AddrErr & ResultSel==01).
  - A misaligned load never writes a register.
- A misaligned store is dropped silently apart from AddrErr.
- No other state exists. The memory contents persist across READY cycles and are cleared only by the reset sequence.

Test Plan:
- Release reset at cycle 0 with ADDR_WIDTH=4 -> Stall=1 for exactly 16 clocks and RegWEOut=0 throughout; Stall=0 on cycle 16; loads of all 16 words return 0.
- In READY, SW Addr=0x10 WData=0xDEADBEEF, next cycle load word Addr=0x10 ResultSel=01 -> ResultOut=0xDEADBEEF, RegWEOut=RegWEIn, AddrErr=0.
- SB WData=0x80 to Addr=0x13, then MemOp=100 at 0x13 -> 0xFFFFFF80; MemOp=011 -> 0x00000080; word load of 0x10 -> 0x80ADBEEF.
- SH Addr=0x11 WData=0x1234 -> AddrErr=1, memory unchanged. Word load Addr=0x12 -> AddrErr=1, ResultOut=0, RegWEOut=0.
- ResultSel=10 with PCIn=0x00003000 -> ResultOut=0x00003008, A3Out=A3In, PCOut=PCIn.
- Pulse reset low for 1 cycle at clear count 7 -> counter restarts; Stall stays high for a full 16 clocks after the second release; prior READY data is erased.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: data memory, load/store lanes, write-back select, post-reset clear
module mem_stage #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWE,
  input  logic [2:0]  MemOp,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [31:0] ResultIn,
  input  logic [1:0]  ResultSel,
  input  logic [4:0]  A3In,
  input  logic        RegWEIn,
  input  logic [31:0] PCIn,
  output logic [31:0] ResultOut,
  output logic [4:0]  A3Out,
  output logic        RegWEOut,
  output logic [31:0] PCOut,
  output logic        Stall,
  output logic        AddrErr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_next;
  logic                  w_ready;
  logic [31:0]           r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_is_half;
  logic                  w_is_byte;
  logic                  w_misaligned;
  logic                  w_store;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_rd_word;
  logic [15:0]           w_rd_half;
  logic [7:0]            w_rd_byte;
  logic [31:0]           w_load;
  logic                  w_unused;

  // Upper address bits are deliberately ignored so the address wraps modulo depth
  assign w_unused = &{1'b0, Addr[31:ADDR_WIDTH+2]};
  assign w_idx    = Addr[ADDR_WIDTH+1:2];
  assign A3Out    = A3In;
  assign PCOut    = PCIn;

  // State and clear counter; reset restarts the clear from word 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state: walk every word once, leave CLEAR on the last one, then stay READY
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ready      = 1'b0;
    Stall        = 1'b1;
    case (r_state)
      S_CLEAR: begin
        w_cnt_next = r_cnt + CNT_ONE;
        if (r_cnt == CNT_LAST) begin
          w_state_next = S_READY;
        end
      end
      default: begin
        w_ready = 1'b1;
        Stall   = 1'b0;
      end
    endcase
  end

  // Access-size decode and alignment; unknown MemOp codes behave as word
  always_comb begin
    w_is_half    = (MemOp == 3'b001) || (MemOp == 3'b010);
    w_is_byte    = (MemOp == 3'b011) || (MemOp == 3'b100);
    w_misaligned = 1'b0;
    if (w_is_half) begin
      w_misaligned = Addr[0];
    end else if (!w_is_byte) begin
      w_misaligned = |Addr[1:0];
    end
  end

  assign AddrErr = w_ready && w_misaligned && (MemWE || (ResultSel == 2'b01));
  assign w_store = w_ready && MemWE && !AddrErr;

  // Store lane enables with the store data replicated onto every candidate lane
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WData;
    if (w_is_half) begin
      w_be    = Addr[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{WData[15:0]}};
    end else if (w_is_byte) begin
      w_be    = 4'b0001 << Addr[1:0];
      w_wdata = {4{WData[7:0]}};
    end
  end

  // Memory: zeroing pass during CLEAR, byte-enabled user stores once READY
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign w_rd_word = r_mem[w_idx];
  assign w_rd_half = Addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  // Byte lane select for loads
  always_comb begin
    case (Addr[1:0])
      2'b00:   w_rd_byte = w_rd_word[7:0];
      2'b01:   w_rd_byte = w_rd_word[15:8];
      2'b10:   w_rd_byte = w_rd_word[23:16];
      default: w_rd_byte = w_rd_word[31:24];
    endcase
  end

  // Load extension; a misaligned load yields zero
  always_comb begin
    case (MemOp)
      3'b001:  w_load = {16'h0000, w_rd_half};
      3'b010:  w_load = {{16{w_rd_half[15]}}, w_rd_half};
      3'b011:  w_load = {24'h000000, w_rd_byte};
      3'b100:  w_load = {{24{w_rd_byte[7]}}, w_rd_byte};
      default: w_load = w_rd_word;
    endcase
    if (w_misaligned) begin
      w_load = '0;
    end
  end

  // Write-back select and register-write gating; both held at zero until READY
  always_comb begin
    ResultOut = '0;
    RegWEOut  = 1'b0;
    if (w_ready) begin
      case (ResultSel)
        2'b01:   ResultOut = w_load;
        2'b10:   ResultOut = PCIn + 32'd8;
        default: ResultOut = ResultIn;
      endcase
      RegWEOut = RegWEIn && !(AddrErr && (ResultSel == 2'b01));
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a word-array model
module tb_mem_stage;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic        clk;
  logic        reset;
  logic        MemWE;
  logic [2:0]  MemOp;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] ResultIn;
  logic [1:0]  ResultSel;
  logic [4:0]  A3In;
  logic        RegWEIn;
  logic [31:0] PCIn;
  logic [31:0] ResultOut;
  logic [4:0]  A3Out;
  logic        RegWEOut;
  logic [31:0] PCOut;
  logic        Stall;
  logic        AddrErr;

  int          n_tests;
  int          n_fail;
  logic [31:0] m_mem [DEPTH];

  mem_stage #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .MemWE(MemWE), .MemOp(MemOp), .Addr(Addr),
    .WData(WData), .ResultIn(ResultIn), .ResultSel(ResultSel), .A3In(A3In),
    .RegWEIn(RegWEIn), .PCIn(PCIn), .ResultOut(ResultOut), .A3Out(A3Out),
    .RegWEOut(RegWEOut), .PCOut(PCOut), .Stall(Stall), .AddrErr(AddrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 2;
    if (op == 3'd3 || op == 3'd4) return 1;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [2:0] op);
    return (a % acc_size(op)) != 0;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [2:0] op);
    int unsigned sz;
    sz = acc_size(op);
    if (sz == 4) return 32'hFFFF_FFFF;
    return (32'd1 << (8 * sz)) - 32'd1;
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % DEPTH;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] v;
    logic [31:0] mask;
    int unsigned sh;
    if (is_mis(a, op)) return 32'h0;
    mask = lane_mask(op);
    sh   = 8 * (a % 4);
    v    = (m_mem[widx(a)] >> sh) & mask;
    if ((op == 3'd2 || op == 3'd4) && (v & ((mask >> 1) + 32'd1)) != 0) v = v | ~mask;
    return v;
  endfunction

  function automatic bit exp_aerr(input logic [31:0] a, input logic [2:0] op, input logic we,
                                  input logic [1:0] sel);
    return is_mis(a, op) && (we || sel == 2'b01);
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
    logic [31:0] mask;
    int unsigned sh;
    mask = lane_mask(op);
    sh   = 8 * (a % 4);
    m_mem[widx(a)] = (m_mem[widx(a)] & ~(mask << sh)) | ((d & mask) << sh);
  endtask

  task automatic check_ready(input string tag);
    logic [31:0] er;
    bit          ae;
    ae = exp_aerr(Addr, MemOp, MemWE, ResultSel);
    case (ResultSel)
      2'b01:   er = exp_load(Addr, MemOp);
      2'b10:   er = PCIn + 32'd8;
      default: er = ResultIn;
    endcase
    chk({tag, "_res"},  ResultOut, er);
    chk({tag, "_aerr"}, {31'b0, AddrErr}, {31'b0, ae});
    chk({tag, "_rwe"},  {31'b0, RegWEOut}, {31'b0, RegWEIn && !(ae && ResultSel == 2'b01)});
    chk({tag, "_a3"},   {27'b0, A3Out}, {27'b0, A3In});
    chk({tag, "_pc"},   PCOut, PCIn);
  endtask

  task automatic tick();
    bit st;
    st = MemWE && !exp_aerr(Addr, MemOp, MemWE, ResultSel);
    @(posedge clk);
    if (st) model_store(Addr, MemOp, WData);
    #1;
  endtask

  task automatic drive_random();
    MemWE     = 1'($urandom);
    MemOp     = 3'($urandom_range(0, 7));
    Addr      = $urandom;
    WData     = $urandom;
    ResultIn  = $urandom;
    ResultSel = 2'($urandom);
    A3In      = 5'($urandom);
    RegWEIn   = 1'($urandom);
    PCIn      = $urandom;
  endtask

  // Releases reset and counts clocks until Stall drops; the memory must be all zero afterwards
  task automatic run_clear();
    int cyc;
    reset = 1'b1;
    cyc   = 0;
    while (cyc < 40) begin
      drive_random();
      #1;
      if (Stall !== 1'b1) break;
      chk("clr_rwe",  {31'b0, RegWEOut}, 32'h0);
      chk("clr_res",  ResultOut, 32'h0);
      chk("clr_aerr", {31'b0, AddrErr}, 32'h0);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("stall_len", cyc, DEPTH);
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    MemWE     = 1'b0;
    MemOp     = 3'd0;
    ResultSel = 2'b01;
    RegWEIn   = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      Addr = 32'(i * 4);
      #1;
      chk("clr_zero", ResultOut, 32'h0);
    end
  endtask

  task automatic set_op(input logic we, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sel);
    MemWE = we; MemOp = op; Addr = a; WData = d; ResultSel = sel;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    drive_random();
    #3;
    chk("rst_stall", {31'b0, Stall}, 32'h1);
    chk("rst_rwe",   {31'b0, RegWEOut}, 32'h0);
    chk("rst_res",   ResultOut, 32'h0);
    chk("rst_pc",    PCOut, PCIn);
    @(posedge clk);
    #1;
    run_clear();

    RegWEIn = 1'b1;
    A3In    = 5'd9;
    set_op(1'b1, 3'd0, 32'h10, 32'hDEADBEEF, 2'b00);
    tick();
    set_op(1'b0, 3'd0, 32'h10, 32'h0, 2'b01);
    chk("sw_load", ResultOut, 32'hDEADBEEF);
    chk("sw_rwe",  {31'b0, RegWEOut}, 32'h1);
    chk("sw_aerr", {31'b0, AddrErr}, 32'h0);

    set_op(1'b1, 3'd3, 32'h13, 32'h80, 2'b00);
    tick();
    set_op(1'b0, 3'd4, 32'h13, 32'h0, 2'b01);
    chk("lb_sext", ResultOut, 32'hFFFFFF80);
    set_op(1'b0, 3'd3, 32'h13, 32'h0, 2'b01);
    chk("lbu_zext", ResultOut, 32'h00000080);
    set_op(1'b0, 3'd0, 32'h10, 32'h0, 2'b01);
    chk("sb_word", ResultOut, 32'h80ADBEEF);

    set_op(1'b1, 3'd1, 32'h11, 32'h1234, 2'b00);
    chk("sh_mis_aerr", {31'b0, AddrErr}, 32'h1);
    tick();
    set_op(1'b0, 3'd0, 32'h10, 32'h0, 2'b01);
    chk("sh_mis_kept", ResultOut, 32'h80ADBEEF);
    set_op(1'b0, 3'd0, 32'h12, 32'h0, 2'b01);
    chk("lw_mis_aerr", {31'b0, AddrErr}, 32'h1);
    chk("lw_mis_res",  ResultOut, 32'h0);
    chk("lw_mis_rwe",  {31'b0, RegWEOut}, 32'h0);

    PCIn = 32'h00003000;
    A3In = 5'd31;
    set_op(1'b0, 3'd0, 32'h0, 32'h0, 2'b10);
    chk("pc8_res", ResultOut, 32'h00003008);
    chk("pc8_a3",  {27'b0, A3Out}, 32'd31);
    chk("pc8_pc",  PCOut, 32'h00003000);

    for (int i = 0; i < 400; i++) begin
      drive_random();
      if ($urandom_range(0, 3) != 0) Addr = Addr & ~32'h3 | 32'($urandom_range(0, 3)) & 32'h2;
      #1;
      check_ready("rnd");
      tick();
    end

    reset = 1'b0;
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_stall", {31'b0, Stall}, 32'h1);
    chk("mid_res",   ResultOut, 32'h0);
    @(posedge clk);
    #1;
    run_clear();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
